// File: rtl/seg7_decode.sv
// seg7_decode: filters and decodes an active-low 7-segment bus into a hex digit.
// Define SEG7_DECODE_DIR_EN to build the UP/DOWN step-direction outputs.
module seg7_decode #(
  parameter int STABLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] SEG,
  output logic [3:0] DIGIT,
  output logic       DVALID,
  output logic       ERR,
  output logic       UP,
  output logic       DOWN,
  output logic [7:0] ERRCNT
);

  typedef enum logic {
    EMPTY,
    HAVE
  } state_e;

  localparam logic [6:0] BLANK = 7'h7f;
  localparam logic [7:0] STAB  = 8'(STABLE_CYC);

  // {recognised, digit}; segment order g..a
  function automatic logic [4:0] dec7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1011000: r = {1'b1, 4'h7};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'ha};
      7'b0000011: r = {1'b1, 4'hb};
      7'b1000110: r = {1'b1, 4'hc};
      7'b0100001: r = {1'b1, 4'hd};
      7'b0000110: r = {1'b1, 4'he};
      7'b0001110: r = {1'b1, 4'hf};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0] s1_q, s2_q, s3_q, last_q;
  logic [6:0] s3_d, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic [3:0] digit_q, digit_d;
  logic       dvalid_q, dvalid_d;
  logic       err_q, err_d;
  logic [7:0] errcnt_q, errcnt_d;
  state_e     state_q, state_d;

  logic       chg, fire, newpat;
  logic       acc_v, acc_e;
  logic [4:0] dec;

  // stability filter and acceptance classification
  always_comb begin
    s3_d     = s2_q;
    chg      = (s2_q != s3_q);
    fire     = armed_q && (cnt_q == STAB);
    newpat   = fire && (s3_q != last_q);
    dec      = dec7(s3_q);
    acc_v    = newpat && dec[4];
    acc_e    = newpat && !dec[4] && (s3_q != BLANK);
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    last_d   = last_q;
    digit_d  = digit_q;
    errcnt_d = errcnt_q;
    state_d  = state_q;
    if (chg) begin
      cnt_d   = 8'd1;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != STAB)
        cnt_d = cnt_q + 8'd1;
      if (fire)
        armed_d = 1'b0;
    end
    if (newpat)
      last_d = s3_q;
    if (acc_v) begin
      digit_d = dec[3:0];
      state_d = HAVE;
    end
    if (acc_e && errcnt_q != 8'hff)
      errcnt_d = errcnt_q + 8'd1;
    dvalid_d = acc_v;
    err_d    = acc_e;
  end

  // synchroniser, filter and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q     <= BLANK;
      s2_q     <= BLANK;
      s3_q     <= BLANK;
      last_q   <= BLANK;
      cnt_q    <= 8'd0;
      armed_q  <= 1'b1;
      digit_q  <= 4'h0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
      state_q  <= EMPTY;
    end else begin
      s1_q     <= SEG;
      s2_q     <= s1_q;
      s3_q     <= s3_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      digit_q  <= digit_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      state_q  <= state_d;
    end
  end

`ifdef SEG7_DECODE_DIR_EN
  logic up_q, up_d, down_q, down_d;

  // step direction relative to the previous digit
  always_comb begin
    up_d   = acc_v && (state_q == HAVE) &&
             (dec[3:0] == digit_q + 4'd1);
    down_d = acc_v && (state_q == HAVE) &&
             (dec[3:0] == digit_q - 4'd1);
  end

  // direction pulse registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= up_d;
      down_q <= down_d;
    end
  end

  assign UP   = up_q;
  assign DOWN = down_q;
`else
  assign UP   = 1'b0;
  assign DOWN = 1'b0;
`endif

  assign DIGIT  = digit_q;
  assign DVALID = dvalid_q;
  assign ERR    = err_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: doc/seg7_decode.md
SEG7_DECODE -- requirements
Module: seg7_decode

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4, range 1..255: consecutive identical samples required before a pattern is accepted.
REQ-002 The block SHALL have port CLK, input, 1 bit: single clock, all state updated on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port SEG, input, 7 bits: active-low segment pattern, bit0=a … bit6=g, asynchronous to CLK, sampled every rising edge.
REQ-005 The block SHALL have port DIGIT, output, 4 bits: last accepted hex value.
REQ-006 The block SHALL have port DVALID, output, 1 bit: one-cycle pulse when DIGIT is updated.
REQ-007 The block SHALL have port ERR, output, 1 bit: one-cycle pulse when a stable, unrecognised pattern is accepted.
REQ-008 The block SHALL have port UP, output, 1 bit: one-cycle pulse with DVALID when the new digit equals the previous digit + 1 mod 16.
REQ-009 The block SHALL have port DOWN, output, 1 bit: one-cycle pulse with DVALID when the new digit equals the previous digit - 1 mod 16.
REQ-010 The block SHALL have port ERRCNT, output, 8 bits: saturating count of ERR pulses.

Function
REQ-011 The decode table SHALL map active-low patterns g..a to digits as follows.
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000.
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1011000 or 1111000.
- 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011.
- C = 1000110, d = 0100001, E = 0000110, F = 0001110.
REQ-012 Pattern 1111111 (blank) SHALL be recognised as blank: no DVALID, no ERR, and the previous digit is unchanged.
REQ-013 Any pattern not in REQ-011 and not blank SHALL be classed as invalid.
REQ-014 SEG SHALL pass through a two-flop synchroniser; the stability filter operates on the synchronised value.
REQ-015 The filter SHALL count consecutive cycles in which the synchronised value equals its previous-cycle value; any change restarts the count at 1.
REQ-016 A pattern SHALL be accepted in the cycle its count reaches STABLE_CYC, and only if it differs from the last accepted pattern (blank included); the acceptance is then armed off until the value changes.
REQ-017 Latency: with SEG held constant from edge k, acceptance outputs SHALL be registered and visible after edge k+2+STABLE_CYC, for exactly one cycle.
REQ-018 Valid acceptance SHALL load DIGIT and pulse DVALID.
REQ-019 Invalid acceptance SHALL pulse ERR, increment ERRCNT (hold at 255), and leave DIGIT unchanged.
REQ-020 Blank acceptance SHALL produce no pulse but SHALL re-arm, so the same digit reappearing after a blank produces a new DVALID.
REQ-021 State machine states: EMPTY (no digit accepted yet), HAVE (a previous digit exists).
- EMPTY → HAVE on the first valid acceptance.
- HAVE persists until reset.
REQ-022 UP and DOWN SHALL be 0 on the first acceptance in EMPTY.
REQ-023 Wrap-around SHALL be detected: F→0 gives UP, 0→F gives DOWN.
REQ-024 Any other jump, and a same digit re-accepted after a blank, SHALL give neither UP nor DOWN.
REQ-025 DVALID, ERR, UP and DOWN SHALL be mutually consistent: UP or DOWN implies DVALID, and ERR never coincides with DVALID.

Reset
REQ-026 While RST=0, all outputs SHALL be 0 and the state SHALL be EMPTY.
REQ-027 While RST=0, the synchroniser, stability count and last-accepted pattern SHALL be cleared to blank (1111111).
REQ-028 Reset asserted mid-count SHALL discard the pending candidate; after release, a full STABLE_CYC count is required.

Configuration
REQ-029 With macro SEG7_DECODE_DIR_EN defined, UP and DOWN SHALL operate per REQ-008, REQ-009 and REQ-021 to REQ-024.
REQ-030 Without SEG7_DECODE_DIR_EN, UP and DOWN SHALL be constant 0, no previous-digit compare logic SHALL be built, and all other behaviour is unchanged.

Verification (STABLE_CYC=4, SEG7_DECODE_DIR_EN defined)
REQ-031 Reset, then SEG=0110000 held → exactly one DVALID with DIGIT=3, UP=0, DOWN=0, at the cycle given by REQ-017.
REQ-032 Step SEG 3→4→5, each held 10 cycles → two DVALID pulses, each with UP=1; then 5→4 → DVALID with DOWN=1.
REQ-033 SEG=0001110 (F), then 1000000 (0) → DVALID with DIGIT=0 and UP=1; then back to F → DOWN=1.
REQ-034 SEG toggles between 2 and 7 every 2 cycles for 40 cycles → no DVALID; ERRCNT stays 0.
REQ-035 SEG=1010101 held → one ERR, ERRCNT=1, DIGIT unchanged; inject 300 distinct invalid episodes → ERRCNT=255 (saturated).
REQ-036 SEG=digit 6 accepted, then blank, then 6 again → second DVALID with UP=0, DOWN=0; RST pulsed low during the third stable cycle → no pulse, and all outputs are 0.
